// File: rtl/fibo_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fibo_seq_gen
//  Description : Fibonacci sequence generator with programmable seeds and
//                term count. One term is emitted per accepted valid/ready
//                transfer; the sequence stops after num_terms terms. Sums
//                either wrap modulo 2^WIDTH or saturate at all-ones.
//  Ports       : clk, reset (sync, active-high)
//                start, seed0, seed1, num_terms   - sequence request
//                out_ready                        - downstream back-pressure
//                out_valid, out_data, out_index   - term stream
//                busy, done, overflow             - status
//  Revision    : 1.0 - initial release
// ============================================================================
module fibo_seq_gen #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             ovf_q, ovf_d;
  // Output copies: they hold the last emitted term/index once the sequence
  // ends, while the internal a/idx registers keep advancing on the final
  // transfer.
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] oidx_q, oidx_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_term;
  logic             last_term;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign last_term = (idx_q == (n_q - CNT_W'(1)));

  generate
    if (SATURATE != 0) begin : g_sat
      assign next_term = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end else begin : g_wrap
      assign next_term = sum[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    oidx_d  = oidx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (num_terms == '0) begin
            // Empty request still completes with a done pulse.
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            a_d     = seed0;
            b_d     = seed1;
            idx_d   = '0;
            n_d     = num_terms;
            data_d  = seed0;
            oidx_d  = '0;
          end
        end
      end

      S_RUN: begin
        if (out_ready) begin
          a_d   = b_q;
          b_d   = next_term;
          idx_d = idx_q + CNT_W'(1);
          // The sum formed on the final transfer also counts toward overflow.
          if (sum[WIDTH]) begin
            ovf_d = 1'b1;
          end
          if (last_term) begin
            state_d = S_DONE;
          end else begin
            data_d = b_q;
            oidx_d = idx_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
    end
  end

  // All outputs decode registered state only: no path from out_ready.
  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_index = oidx_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fibo_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fibo_seq_gen
//  Description : Bench for fibo_seq_gen. Three instances share one stimulus:
//                WIDTH=4 wrap, WIDTH=4 saturate, WIDTH=8 wrap. A reference
//                model derives each term directly from the recurrence and is
//                compared with every instance each cycle; literal term lists
//                pin the model to hand-computed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fibo_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed0, seed1;
  logic [7:0] num_terms;
  logic       out_ready;

  always #5 clk = ~clk;

  logic [3:0] d0_data, d1_data;
  logic [7:0] d2_data;
  logic [7:0] d_idx   [3];
  logic       d_valid [3];
  logic       d_busy  [3];
  logic       d_done  [3];
  logic       d_ovf   [3];
  int         d_dat   [3];

  fibo_seq_gen #(.WIDTH(4), .CNT_W(8), .SATURATE(0)) u_w4 (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0[3:0]), .seed1(seed1[3:0]),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(d_valid[0]),
    .out_data(d0_data), .out_index(d_idx[0]), .busy(d_busy[0]), .done(d_done[0]),
    .overflow(d_ovf[0]));

  fibo_seq_gen #(.WIDTH(4), .CNT_W(8), .SATURATE(1)) u_s4 (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0[3:0]), .seed1(seed1[3:0]),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(d_valid[1]),
    .out_data(d1_data), .out_index(d_idx[1]), .busy(d_busy[1]), .done(d_done[1]),
    .overflow(d_ovf[1]));

  fibo_seq_gen #(.WIDTH(8), .CNT_W(8), .SATURATE(0)) u_w8 (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(d_valid[2]),
    .out_data(d2_data), .out_index(d_idx[2]), .busy(d_busy[2]), .done(d_done[2]),
    .overflow(d_ovf[2]));

  always_comb begin
    d_dat[0] = int'(d0_data);
    d_dat[1] = int'(d1_data);
    d_dat[2] = int'(d2_data);
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t got %0d expected %0d", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_w   [3] = '{4, 4, 8};
  int m_sat [3] = '{0, 1, 0};

  // Term k and k+1 of the sequence, plus whether term(k)+term(k+1) exceeds
  // the representable range.
  function automatic void fib_at(input int s0, input int s1, input int k,
                                 input int w, input int sat,
                                 output int tk, output int tk1, output bit ov);
    int mx, a, b, s;
    mx = (1 << w) - 1;
    a  = s0;
    b  = s1;
    for (int j = 0; j < k; j++) begin
      s = a + b;
      a = b;
      b = (s > mx) ? (sat != 0 ? mx : (s & mx)) : s;
    end
    tk  = a;
    tk1 = b;
    ov  = ((a + b) > mx);
  endfunction

  int m_mode [3];  // 0 idle, 1 emitting, 2 finishing
  int m_s0   [3];
  int m_s1   [3];
  int m_n    [3];
  int m_k    [3];
  int m_data [3];
  int m_idx  [3];
  bit m_ovf  [3];

  int got0[$], got1[$], got2[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_s0[i] = 0; m_s1[i] = 0; m_n[i] = 0;
      m_k[i] = 0; m_data[i] = 0; m_idx[i] = 0; m_ovf[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        int tk, tk1;
        bit ov;
        int mx;
        mx = (1 << m_w[i]) - 1;
        if (reset) begin
          m_mode[i] = 0; m_data[i] = 0; m_idx[i] = 0; m_ovf[i] = 1'b0;
        end else if (m_mode[i] == 0) begin
          if (start) begin
            m_ovf[i] = 1'b0;
            if (num_terms == 8'd0) begin
              m_mode[i] = 2;
            end else begin
              m_mode[i] = 1;
              m_s0[i]   = int'(seed0) & mx;
              m_s1[i]   = int'(seed1) & mx;
              m_n[i]    = int'(num_terms);
              m_k[i]    = 0;
              m_data[i] = m_s0[i];
              m_idx[i]  = 0;
            end
          end
        end else if (m_mode[i] == 1) begin
          if (out_ready) begin
            fib_at(m_s0[i], m_s1[i], m_k[i], m_w[i], m_sat[i], tk, tk1, ov);
            if (ov) m_ovf[i] = 1'b1;
            if (m_k[i] == m_n[i] - 1) begin
              m_mode[i] = 2;
            end else begin
              m_k[i]++;
              m_data[i] = tk1;
              m_idx[i]  = m_k[i];
            end
          end
        end else begin
          m_mode[i] = 0;
        end
      end

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("valid",    i, int'(d_valid[i]), int'(m_mode[i] == 1));
        chk("busy",     i, int'(d_busy[i]),  int'(m_mode[i] == 1));
        chk("done",     i, int'(d_done[i]),  int'(m_mode[i] == 2));
        chk("data",     i, d_dat[i],         m_data[i]);
        chk("index",    i, int'(d_idx[i]),   m_idx[i]);
        chk("overflow", i, int'(d_ovf[i]),   int'(m_ovf[i]));
      end
      // Log each term that will be accepted at the coming edge.
      if (!reset && out_ready) begin
        if (d_valid[0]) got0.push_back(d_dat[0]);
        if (d_valid[1]) got1.push_back(d_dat[1]);
        if (d_valid[2]) got2.push_back(d_dat[2]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got0.delete();
    got1.delete();
    got2.delete();
  endtask

  task automatic check_seq(input string name, input int inst);
    int g[$];
    case (inst)
      0:       g = got0;
      1:       g = got1;
      default: g = got2;
    endcase
    chk({name, "_len"}, inst, g.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < g.size(); k++) begin
      chk({name, "_term"}, inst, g[k], exp_q[k]);
    end
  endtask

  task automatic do_start(input int s0, input int s1, input int n);
    seed0     = 8'(s0);
    seed1     = 8'(s1);
    num_terms = 8'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Wait until every instance is back in idle (not busy, no done pulse).
  task automatic wait_idle(input int budget, input bit rnd_ready);
    int c;
    c = 0;
    while ((d_busy[0] || d_busy[1] || d_busy[2] ||
            d_done[0] || d_done[1] || d_done[2]) && c < budget) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    out_ready = 1'b1;
    vectors++;
    if (c >= budget) begin
      miscompares++;
      $display("FAIL wait_idle timeout after %0d cycles", c);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; num_terms = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", i, int'(d_valid[i]), 0);
      chk("rst_data",  i, d_dat[i], 0);
      chk("rst_ovf",   i, int'(d_ovf[i]), 0);
    end

    // Test 1: seeds 0,1, eight terms, ready held high.
    clear_logs();
    do_start(0, 1, 8);
    wait_idle(100, 1'b0);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
    check_seq("t1_w8", 2);
    check_seq("t1_w4", 0);
    chk("t1_ovf_w8", 2, int'(d_ovf[2]), 0);
    chk("t1_ovf_w4", 0, int'(d_ovf[0]), 1);  // 8+13 already exceeds 4 bits

    // Tests 2/3: ten terms, wrap vs saturate.
    clear_logs();
    do_start(0, 1, 10);
    wait_idle(100, 1'b0);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
    check_seq("t2_wrap", 0);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 15, 15};
    check_seq("t3_sat", 1);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    check_seq("t2_w8", 2);
    chk("t2_ovf", 0, int'(d_ovf[0]), 1);
    chk("t3_ovf", 1, int'(d_ovf[1]), 1);

    // Test 4: random back-pressure.
    clear_logs();
    do_start(0, 1, 8);
    wait_idle(400, 1'b1);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
    check_seq("t4_bp", 2);

    // Test 5a: zero terms, only a done pulse.
    clear_logs();
    do_start(3, 4, 0);
    chk("t5_done", 2, int'(d_done[2]), 1);
    wait_idle(10, 1'b0);
    exp_q = {};
    check_seq("t5_empty", 2);
    chk("t5_ovf", 2, int'(d_ovf[2]), 0);

    // Test 5b: start during RUN must be ignored.
    clear_logs();
    do_start(0, 1, 8);
    tick();
    do_start(5, 5, 3);
    seed0 = 8'd9; seed1 = 8'd9;
    wait_idle(100, 1'b0);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
    check_seq("t5_ignore", 2);

    // Test 6: reset while index 3 is presented, then restart.
    do_start(0, 1, 8);
    begin
      int c;
      c = 0;
      while (d_idx[2] != 8'd3 && c < 50) begin
        tick();
        c++;
      end
      chk("t6_reach_idx3", 2, int'(d_idx[2]), 3);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_valid", i, int'(d_valid[i]), 0);
      chk("t6_done",  i, int'(d_done[i]),  0);
      chk("t6_data",  i, d_dat[i], 0);
      chk("t6_index", i, int'(d_idx[i]), 0);
    end
    clear_logs();
    do_start(2, 3, 4);
    wait_idle(100, 1'b0);
    exp_q = '{2, 3, 5, 8};
    check_seq("t6_restart_w8", 2);
    check_seq("t6_restart_w4", 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
